mic1_reg_bank: RTL

- MIC-1 datapath register bank, directly downstream of the shifter.
- Latches the 32-bit C bus (shifter output `Shift`) into the registers selected by the 9-bit C control.
- Drives the B bus and the H (A-bus) operand back to the ALU.
- Owns the MAR/MDR word port and the PC/MBR byte-fetch port, each with an ack handshake and at most one transaction outstanding; also registers the N/Z flags.

---
 rtl/mic1_pkg.sv | 30 +++
 rtl/mic1_mem_port.sv | 45 ++++
 rtl/mic1_reg_bank.sv | 118 +++++++++++
 3 files changed

// File: rtl/mic1_pkg.sv
// mic1_pkg: shared constants for the MIC-1 register bank.
//   C-bus write-enable bit indices, B-bus source encoding,
//   memory-port FSM states and the default datapath width.
package mic1_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int C_MAR = 0;
    localparam int C_MDR = 1;
    localparam int C_PC  = 2;
    localparam int C_SP  = 3;
    localparam int C_LV  = 4;
    localparam int C_CPP = 5;
    localparam int C_TOS = 6;
    localparam int C_OPC = 7;
    localparam int C_H   = 8;
    typedef enum logic [3:0] {
        B_MDR  = 4'd0,
        B_PC   = 4'd1,
        B_MBR  = 4'd2,
        B_MBRU = 4'd3,
        B_SP   = 4'd4,
        B_LV   = 4'd5,
        B_CPP  = 4'd6,
        B_TOS  = 4'd7,
        B_OPC  = 4'd8
    } b_sel_e;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } port_st_e;
endpackage

// File: rtl/mic1_mem_port.sv
// mic1_mem_port: single-outstanding request FSM (IDLE -> REQ -> IDLE).
//   Ports: clk_i, rst_i (async, active-high), start_i (new request),
//   ack_i (memory acknowledge), req_o (strobe, high in REQ),
//   done_o (ack accepted this cycle), err_o (start while busy, or timeout).
//   Macro MEM_TIMEOUT_EN: abort REQ after TIMEOUT_CYCLES cycles without ack.
module mic1_mem_port
    import mic1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic ack_i,
    output logic req_o,
    output logic done_o,
    output logic err_o
);
    port_st_e state_q, state_d;
    logic tmo;
`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // Counter restarts from zero every time the port passes through IDLE.
    assign cnt_d = (state_q == ST_REQ) ? cnt_q + 1'b1 : '0;
    assign tmo   = (state_q == ST_REQ) && !ack_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    logic unused_to;
    assign unused_to = TIMEOUT_CYCLES > 0;
    assign tmo       = 1'b0;
`endif
    assign state_d = (state_q == ST_IDLE) ? (start_i ? ST_REQ : ST_IDLE)
                                          : ((ack_i || tmo) ? ST_IDLE : ST_REQ);
    assign req_o   = state_q == ST_REQ;
    assign done_o  = (state_q == ST_REQ) && ack_i;
    assign err_o   = ((state_q == ST_REQ) && start_i) || tmo;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end
endmodule

// File: rtl/mic1_reg_bank.sv
// mic1_reg_bank: MIC-1 register bank with C-bus writes, B/H bus outputs,
//   N/Z flags, a MAR/MDR word port and a PC/MBR byte-fetch port.
//   Ports: CLK, RST (async, active-high), Shift, ALU_out, C_SEL, B_SEL,
//   RD/WR/FETCH, B_bus, H_bus, N, Z, Mem_* word port, Fetch_* byte port,
//   Busy, Err (sticky until reset).
//   Macro MEM_TIMEOUT_EN: enables per-port request timeout.
module mic1_reg_bank
    import mic1_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] Shift,
    input  logic [DATA_W-1:0] ALU_out,
    input  logic [8:0]        C_SEL,
    input  logic [3:0]        B_SEL,
    input  logic              RD,
    input  logic              WR,
    input  logic              FETCH,
    output logic [DATA_W-1:0] B_bus,
    output logic [DATA_W-1:0] H_bus,
    output logic              N,
    output logic              Z,
    output logic [DATA_W-1:0] Mem_addr,
    output logic              Mem_rd,
    output logic              Mem_wr,
    output logic [DATA_W-1:0] Mem_wdata,
    input  logic [DATA_W-1:0] Mem_rdata,
    input  logic              Mem_ack,
    output logic [DATA_W-1:0] Fetch_addr,
    output logic              Fetch_req,
    input  logic [7:0]        Fetch_data,
    input  logic              Fetch_ack,
    output logic              Busy,
    output logic              Err
);
    logic [DATA_W-1:0] h_q, opc_q, tos_q, cpp_q, lv_q, sp_q, pc_q, mar_q, mdr_q, mdr_d;
    logic [7:0]        mbr_q, mbr_d;
    logic              n_q, z_q, err_q, err_d, wr_q, wr_d;
    logic              word_go, w_req, w_done, w_err, f_req, f_done, f_err;
    // RD and WR together is a conflict, so only exactly one of them starts a request.
    assign word_go = RD ^ WR;
    mic1_mem_port #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_word (
        .clk_i(CLK), .rst_i(RST), .start_i(word_go), .ack_i(Mem_ack),
        .req_o(w_req), .done_o(w_done), .err_o(w_err)
    );
    mic1_mem_port #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fetch (
        .clk_i(CLK), .rst_i(RST), .start_i(FETCH), .ack_i(Fetch_ack),
        .req_o(f_req), .done_o(f_done), .err_o(f_err)
    );
    // Direction is captured only when the word port accepts a new request.
    assign wr_d  = (!w_req && word_go) ? WR : wr_q;
    // Returning read data takes priority over a same-edge C-bus write.
    assign mdr_d = (w_done && !wr_q) ? Mem_rdata : (C_SEL[C_MDR] ? Shift : mdr_q);
    assign mbr_d = f_done ? Fetch_data : mbr_q;
    assign err_d = err_q | (RD & WR) | w_err | f_err;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_q   <= '0;
            opc_q <= '0;
            tos_q <= '0;
            cpp_q <= '0;
            lv_q  <= '0;
            sp_q  <= '0;
            pc_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            mbr_q <= '0;
            wr_q  <= 1'b0;
            err_q <= 1'b0;
            n_q   <= 1'b0;
            z_q   <= 1'b1;
        end else begin
            if (C_SEL[C_H])   h_q   <= Shift;
            if (C_SEL[C_OPC]) opc_q <= Shift;
            if (C_SEL[C_TOS]) tos_q <= Shift;
            if (C_SEL[C_CPP]) cpp_q <= Shift;
            if (C_SEL[C_LV])  lv_q  <= Shift;
            if (C_SEL[C_SP])  sp_q  <= Shift;
            if (C_SEL[C_PC])  pc_q  <= Shift;
            if (C_SEL[C_MAR]) mar_q <= Shift;
            mdr_q <= mdr_d;
            mbr_q <= mbr_d;
            wr_q  <= wr_d;
            err_q <= err_d;
            n_q   <= ALU_out[DATA_W-1];
            z_q   <= ALU_out == '0;
        end
    end
    always_comb begin
        B_bus = '0;
        case (b_sel_e'(B_SEL))
            B_MDR:   B_bus = mdr_q;
            B_PC:    B_bus = pc_q;
            B_MBR:   B_bus = {{(DATA_W-8){mbr_q[7]}}, mbr_q};
            B_MBRU:  B_bus = DATA_W'(mbr_q);
            B_SP:    B_bus = sp_q;
            B_LV:    B_bus = lv_q;
            B_CPP:   B_bus = cpp_q;
            B_TOS:   B_bus = tos_q;
            B_OPC:   B_bus = opc_q;
            default: B_bus = '0;
        endcase
    end
    assign H_bus      = h_q;
    assign N          = n_q;
    assign Z          = z_q;
    assign Mem_addr   = mar_q;
    assign Mem_wdata  = mdr_q;
    assign Mem_rd     = w_req & ~wr_q;
    assign Mem_wr     = w_req & wr_q;
    assign Fetch_addr = pc_q;
    assign Fetch_req  = f_req;
    assign Busy       = w_req | f_req;
    assign Err        = err_q;
endmodule
